frame_sync_demod: RTL

Parametrised serial frame-sync demodulator. It searches a qualified serial bitstream for a configurable sync word, tolerating a bounded number of bit errors, then forwards a counted or externally terminated payload. It then re-arms for the next frame. It sits between the bit slicer and the frame deframer/decoder, and is the generalised successor of the fixed 80-bit preamble detector.

---
 rtl/frame_sync_demod.sv | 128 ++++++++++++
 1 files changed

// File: rtl/frame_sync_demod.sv
// Serial frame-sync demodulator: hunts for SYNC_WORD in a qualified bitstream, then forwards a
// counted or externally terminated payload. Define FSD_TOLERANT_EN for Hamming-distance matching.
module frame_sync_demod #(
    parameter int unsigned       SYNC_W    = 80,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 80'hF398_AAAA_AAAA_AAAA_AAAA,
    parameter int unsigned       MAX_ERR   = 0,
    parameter int unsigned       LEN_W     = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         data_in,
    input  logic                         data_in_valid,
    input  logic [LEN_W-1:0]             frame_len,
    input  logic                         fsc_end,
    output logic                         data_out,
    output logic                         data_out_valid,
    output logic                         locked,
    output logic                         frame_done,
    output logic                         frame_abort,
    output logic [$clog2(SYNC_W+1)-1:0]  sync_dist
);

    localparam int unsigned DistW = $clog2(SYNC_W + 1);

    typedef enum logic {StSearch, StPayload} state_e;

    state_e            state_q;
    logic [SYNC_W-1:0] shift_q;
    logic [SYNC_W-1:0] shift_d;
    logic [LEN_W-1:0]  cnt_q;
    logic              unbounded_q;
    logic              data_out_q;
    logic              data_out_valid_q;
    logic              frame_done_q;
    logic              frame_abort_q;
    logic              locked_q;
    logic              match;
    logic              lock_hit;

    // Newest bit enters at the top; the match looks at the word including it.
    assign shift_d  = {data_in, shift_q[SYNC_W-1:1]};
    assign lock_hit = (state_q == StSearch) && data_in_valid && match;

`ifdef FSD_TOLERANT_EN
    logic [DistW-1:0] dist_d;
    logic [DistW-1:0] sync_dist_q;

    assign dist_d = DistW'($countones(shift_d ^ SYNC_WORD));
    assign match  = (32'(dist_d) <= MAX_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_dist_q <= '0;
        end else if (lock_hit) begin
            sync_dist_q <= dist_d;
        end
    end

    assign sync_dist = sync_dist_q;
`else
    logic unused_max_err;

    assign match          = (shift_d == SYNC_WORD);
    assign sync_dist      = '0;
    assign unused_max_err = (MAX_ERR != 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StSearch;
            shift_q          <= '1;
            cnt_q            <= '0;
            unbounded_q      <= 1'b0;
            data_out_q       <= 1'b0;
            data_out_valid_q <= 1'b0;
            frame_done_q     <= 1'b0;
            frame_abort_q    <= 1'b0;
            locked_q         <= 1'b0;
        end else begin
            data_out_valid_q <= 1'b0;
            frame_done_q     <= 1'b0;
            frame_abort_q    <= 1'b0;
            unique case (state_q)
                StSearch: begin
                    if (data_in_valid) begin
                        if (match) begin
                            state_q     <= StPayload;
                            cnt_q       <= frame_len;
                            unbounded_q <= (frame_len == '0);
                            locked_q    <= 1'b1;
                        end else begin
                            shift_q <= shift_d;
                        end
                    end
                end
                StPayload: begin
                    // An external end wins over a coincident payload bit, which is dropped.
                    if (fsc_end) begin
                        state_q       <= StSearch;
                        shift_q       <= '1;
                        locked_q      <= 1'b0;
                        frame_abort_q <= 1'b1;
                    end else if (data_in_valid) begin
                        data_out_q       <= data_in;
                        data_out_valid_q <= 1'b1;
                        if (!unbounded_q) begin
                            cnt_q <= cnt_q - LEN_W'(1);
                            if (cnt_q == LEN_W'(1)) begin
                                state_q      <= StSearch;
                                shift_q      <= '1;
                                locked_q     <= 1'b0;
                                frame_done_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= StSearch;
            endcase
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign frame_done     = frame_done_q;
    assign frame_abort    = frame_abort_q;
    assign locked         = locked_q;

endmodule
